// File: rtl/mul_secuenciador.sv
// Operand sequencer and result buffer for the Booth multiplicador: pulses mul_reset, waits for Fin
// (or times out), then parks the product in a valid/ready output register; DONE stalls while it is full.
module mul_secuenciador #(
    parameter int N          = 3,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_multiplicando,
    input  logic [N-1:0]   in_multiplicador,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_result,
    output logic           out_err,
    output logic           busy,
    output logic [N-1:0]   mul_multiplicando,
    output logic [N-1:0]   mul_multiplicador,
    output logic           mul_reset,
    input  logic [2*N-1:0] mul_result,
    input  logic           mul_fin
);

    localparam int PW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PW-1:0]    pulse_cnt;
    logic [WW-1:0]    wait_cnt;
    logic [2*N-1:0]   res_q;
    logic             err_q;
    logic             accept;
    logic             pulse_last;
    logic             timeout_hit;
    logic             load_out;

    assign in_ready    = (state == IDLE) && !reset;
    assign busy        = (state != IDLE);
    assign mul_reset   = reset || (state == START);
    assign accept      = in_valid && in_ready;
    assign pulse_last  = (pulse_cnt == PW'(RST_CYCLES - 1));
    assign timeout_hit = (wait_cnt == WW'(TIMEOUT - 1));
    assign load_out    = (state == DONE) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = START;
            START:   if (pulse_last) state_nx = SETTLE;
            SETTLE:  state_nx = WAIT;
            WAIT:    if (mul_fin || timeout_hit) state_nx = DONE;
            DONE:    if (load_out) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands stay on the multiplier until the next acceptance, even while DONE stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_multiplicando <= '0;
            mul_multiplicador <= '0;
            pulse_cnt         <= '0;
            wait_cnt          <= '0;
            res_q             <= '0;
            err_q             <= 1'b0;
        end else begin
            if (accept) begin
                mul_multiplicando <= in_multiplicando;
                mul_multiplicador <= in_multiplicador;
                pulse_cnt         <= '0;
            end
            if (state == START) begin
                pulse_cnt <= pulse_cnt + PW'(1);
            end
            if (state == SETTLE) begin
                wait_cnt <= '0;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + WW'(1);
                // Fin takes priority over a timeout landing in the same cycle.
                if (mul_fin) begin
                    res_q <= mul_result;
                    err_q <= 1'b0;
                end else if (timeout_hit) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
        end else if (load_out) begin
            out_valid  <= 1'b1;
            out_result <= res_q;
            out_err    <= err_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_secuenciador.sv
// Directed bench for mul_secuenciador with a behavioural multiplier whose Fin timing is selectable.
module tb_mul_secuenciador;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_multiplicando;
    logic [N-1:0]   in_multiplicador;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_result;
    logic           out_err;
    logic           busy;
    logic [N-1:0]   mul_multiplicando;
    logic [N-1:0]   mul_multiplicador;
    logic           mul_reset;
    logic [2*N-1:0] mul_result;
    logic           mul_fin;

    int n_cmp  = 0;
    int n_fail = 0;
    int fin_mode = 0;  // 0: Fin after 4 cycles out of reset, 1: stuck high, 2: stuck low
    logic [7:0] mcnt;
    logic signed [2*N-1:0] ea, eb;

    mul_secuenciador #(.N(N), .RST_CYCLES(2), .TIMEOUT(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_multiplicando  (in_multiplicando),
        .in_multiplicador  (in_multiplicador),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_result        (out_result),
        .out_err           (out_err),
        .busy              (busy),
        .mul_multiplicando (mul_multiplicando),
        .mul_multiplicador (mul_multiplicador),
        .mul_reset         (mul_reset),
        .mul_result        (mul_result),
        .mul_fin           (mul_fin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_reset) mcnt <= 8'd0;
        else if (mcnt != 8'd255) mcnt <= mcnt + 8'd1;
    end

    always_comb begin
        ea = 6'($signed(mul_multiplicando));
        eb = 6'($signed(mul_multiplicador));
        mul_result = ea * eb;
        if (fin_mode == 1)      mul_fin = 1'b1;
        else if (fin_mode == 2) mul_fin = 1'b0;
        else                    mul_fin = (mcnt >= 8'd4);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench one cycle after the acceptance edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        int g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        in_valid         = 1'b1;
        in_multiplicando = a;
        in_multiplicador = b;
        tick();
        in_valid = 1'b0;
    endtask

    // lat counts clock edges since acceptance until out_valid is seen.
    task automatic wait_out(output int lat, output int rst_hi);
        lat    = 1;
        rst_hi = mul_reset ? 1 : 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
            if (mul_reset) rst_hi++;
        end
    endtask

    initial begin
        int lat;
        int rh;
        int bad;

        reset = 1'b1;
        in_valid = 1'b0;
        in_multiplicando = '0;
        in_multiplicador = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_ops", 32'({mul_multiplicando, mul_multiplicador}), 32'd0);
        chk("rst_mul_reset", 32'(mul_reset), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_mul_reset", 32'(mul_reset), 32'd0);

        // 3 x 2, Fin on the fourth WAIT cycle
        send(3'b011, 3'b010);
        wait_out(lat, rh);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_mul_reset_cycles", 32'(rh), 32'd2);
        chk("t1_result", 32'(out_result), 32'b000110);
        chk("t1_err", 32'(out_err), 32'd0);
        tick();
        chk("t1_single_pulse", 32'(out_valid), 32'd0);

        send(3'b100, 3'b011);
        wait_out(lat, rh);
        chk("t2_neg12", 32'(out_result), 32'b110100);
        chk("t2_neg12_err", 32'(out_err), 32'd0);
        send(3'b100, 3'b100);
        wait_out(lat, rh);
        chk("t2_pos16", 32'(out_result), 32'b010000);
        chk("t2_pos16_err", 32'(out_err), 32'd0);

        // Fin stuck high: SETTLE must ignore it, first WAIT cycle completes
        fin_mode = 1;
        send(3'b011, 3'b011);
        wait_out(lat, rh);
        chk("t3_stale_latency", 32'(lat), 32'd6);
        chk("t3_stale_result", 32'(out_result), 32'b001001);

        fin_mode = 2;
        send(3'b010, 3'b010);
        wait_out(lat, rh);
        chk("t3_timeout_latency", 32'(lat), 32'd21);
        chk("t3_timeout_valid", 32'(out_valid), 32'd1);
        chk("t3_timeout_err", 32'(out_err), 32'd1);
        chk("t3_timeout_result", 32'(out_result), 32'd0);
        tick();

        // Backpressure: one result held, the next one stalls in DONE
        fin_mode = 0;
        out_ready = 1'b0;
        send(3'b011, 3'b010);
        wait_out(lat, rh);
        chk("t4_first_latency", 32'(lat), 32'd9);
        send(3'b100, 3'b011);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!out_valid || out_result != 6'b000110 || out_err) bad++;
        end
        chk("t4_hold_stable", 32'(bad), 32'd0);
        chk("t4_in_ready_stall", 32'(in_ready), 32'd0);
        chk("t4_busy_stall", 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t4_reload_valid", 32'(out_valid), 32'd1);
        chk("t4_reload_result", 32'(out_result), 32'b110100);
        chk("t4_reload_idle", 32'(busy), 32'd0);
        tick();
        chk("t4_drained", 32'(out_valid), 32'd0);

        // Reset in WAIT with a result pending
        out_ready = 1'b0;
        send(3'b001, 3'b011);
        wait_out(lat, rh);
        chk("t5_pending_result", 32'(out_result), 32'b000011);
        fin_mode = 2;
        send(3'b010, 3'b001);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_mul_reset_during_rst", 32'(mul_reset), 32'd1);
        chk("t5_in_ready_during_rst", 32'(in_ready), 32'd0);
        tick();
        chk("t5_idle_after_rst", 32'(busy), 32'd0);
        chk("t5_valid_dropped", 32'(out_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("t5_in_ready_after_rst", 32'(in_ready), 32'd1);
        fin_mode = 0;
        out_ready = 1'b1;
        send(3'b001, 3'b001);
        wait_out(lat, rh);
        chk("t5_one_latency", 32'(lat), 32'd9);
        chk("t5_one_result", 32'(out_result), 32'b000001);

        // in_valid held while busy with changing data
        tick();
        send(3'b010, 3'b011);
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_multiplicando = 3'($urandom);
            in_multiplicador = 3'($urandom);
            tick();
            if (mul_multiplicando != 3'b010 || mul_multiplicador != 3'b011) bad++;
        end
        in_valid = 1'b0;
        chk("t6_operands_held", 32'(bad), 32'd0);
        wait_out(lat, rh);
        chk("t6_result", 32'(out_result), 32'b000110);
        chk("t6_valid", 32'(out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_secuenciador.md
Name: mul_secuenciador

Overview:
- Upstream operand sequencer and result buffer for the 3-bit Booth `multiplicador` block.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the multiplier inputs.
- Starts each multiplication by pulsing the multiplier's reset, waits for `Fin`, then captures the 6-bit product into an output register with valid/ready and timeout detection.

Parameters:
- N, 3: operand width; product width is 2N.
- RST_CYCLES, 2: number of cycles `mul_reset` is held high to start an operation (≥1).
- TIMEOUT, 16: maximum WAIT cycles before the operation is aborted with an error (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer can accept an operand pair.
- in_multiplicando  in  N  two's-complement multiplicand.
- in_multiplicador  in  N  two's-complement multiplier.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result.
- out_result  out  2N  two's-complement product.
- out_err  out  1  qualifies out_result; 1 means timeout, result invalid.
- busy  out  1  high in every state except IDLE.
- mul_multiplicando  out  N  drives the multiplier's multiplicando input.
- mul_multiplicador  out  N  drives the multiplier's multiplicador input.
- mul_reset  out  1  drives the multiplier's reset input.
- mul_result  in  2N  multiplier product.
- mul_fin  in  1  multiplier Fin.

Behaviour:
- Clocking and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - out_valid = 0, out_result = 0, out_err = 0.
  - mul_multiplicando = 0, mul_multiplicador = 0.
  - Wait counter = 0, pulse counter = 0.
- Combinational outputs:
  - mul_reset = reset OR (state == START).
  - in_ready = (state == IDLE) AND NOT reset.
  - busy = (state != IDLE).
- States:
  - IDLE, START, SETTLE, WAIT, DONE, as described in the transitions below.
- IDLE:
  - On in_valid && in_ready, latch both operands into the mul_* registers and go to START.
  - The mul_* registers change only on acceptance.
- START:
  - mul_reset is high.
  - The pulse counter counts RST_CYCLES cycles, then the state goes to SETTLE.
- SETTLE:
  - One cycle; mul_fin is ignored (this masks a stale Fin from the previous operation).
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - The wait counter increments every cycle.
  - mul_fin = 1: latch mul_result internally with err = 0, then go to DONE.
  - Else, if the counter reaches TIMEOUT: set the internal result to 0 with err = 1, then go to DONE.
  - If mul_fin and the timeout occur in the same cycle, mul_fin wins.
- DONE:
  - If out_valid == 0, or out_valid && out_ready in this cycle: load out_result and out_err, set out_valid = 1, go to IDLE.
  - Otherwise stall in DONE; the operands remain on the mul_* outputs and the multiplier is not restarted.
- Output handshake:
  - A transfer occurs on out_valid && out_ready.
  - out_valid clears after a transfer unless DONE reloads it in the same cycle; a simultaneous reload keeps out_valid = 1 with the new data.
  - out_result and out_err are stable while out_valid && !out_ready.
- Throughput: one result can be pending in the output register while the next operation runs. This gives a two-deep effective buffer: the output register plus DONE.
- Latency: acceptance in cycle 0 → START cycles 1..RST_CYCLES → SETTLE at RST_CYCLES+1 → WAIT from RST_CYCLES+2 → out_valid the cycle after DONE is entered, when unblocked.
- Arithmetic: out_result is mul_result passed through unchanged; the sequencer performs no arithmetic.
- Reset mid-operation: from any state, the next state is IDLE. The pending result is dropped, out_valid = 0, and mul_reset is high during the reset cycle.
- in_valid while busy is ignored, since in_ready = 0; the offered data must be held by the producer.

Test Plan:
- Accept 3 × 2 (011, 010), model Fin after 4 WAIT cycles, out_ready = 1 → out_result = 000110, out_err = 0, one out_valid pulse; mul_reset high for exactly 2 cycles after acceptance.
- -4 × 3 (100, 011) → out_result = 110100 (-12); then -4 × -4 (100, 100) → 010000 (16), err = 0.
- mul_fin held at 1 from the previous operation through START/SETTLE and never dropping → stale Fin ignored in SETTLE; the next Fin seen in WAIT completes the operation. With mul_fin tied to 0 → after TIMEOUT = 16 WAIT cycles, out_valid = 1, out_err = 1, out_result = 0.
- out_ready = 0 for 20 cycles with two operations issued → first result held stable; second stalls in DONE with in_ready = 0. Raising out_ready delivers 6 then -12 on consecutive handshakes.
- Assert reset during WAIT → next cycle state IDLE, out_valid = 0, in_ready = 1 once reset drops. A new operation 1 × 1 → 000001.
- in_valid held high while busy with changing data → only the value present at the acceptance edge reaches mul_multiplicando/mul_multiplicador.
